// File: rtl/alien_hit_detector_pkg.sv
// alien_hit_detector_pkg: geometry shared with the formation mover and renderer, FSM encoding, index and score helpers.
package alien_hit_detector_pkg;
    localparam int ROWS      = 5;
    localparam int COLS      = 11;
    localparam int PITCH_X   = 24;
    localparam int PITCH_Y   = 24;
    localparam int ALIEN_W   = 16;
    localparam int ALIEN_H   = 16;
    localparam int SCORE_INC = 10;
    localparam int N_CELLS   = ROWS * COLS;
    localparam int ROW_W     = 3;
    localparam int COL_W     = 4;
    localparam int IDX_W     = $clog2(N_CELLS);

    typedef enum logic [2:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_CHECK, S_HIT, S_COOLDOWN} state_t;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return IDX_W'(int'(r) * COLS + int'(c));
    endfunction

    function automatic logic [15:0] score_add(input logic [15:0] s);
        return (s > 16'(16'hFFFF - SCORE_INC)) ? 16'hFFFF : s + 16'(SCORE_INC);
    endfunction
endpackage

// File: rtl/alien_hit_detector_if.sv
// alien_hit_detector_if: bullet block <-> hit detector link.
// Ports: bullet_x/bullet_y position, bullet_active in-flight flag, hit_reset kill pulse back to the bullet block.
interface alien_hit_detector_if;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_active;
    logic       hit_reset;
    modport master (output bullet_x, bullet_y, bullet_active, input hit_reset);
    modport slave  (input bullet_x, bullet_y, bullet_active, output hit_reset);
endinterface

// File: rtl/alien_hit_detector_grid_locator.sv
// alien_hit_detector_grid_locator: subtract-and-count divider mapping a grid-relative offset to row/col plus in-sprite test.
// Ports: start_i loads rem_x_i/rem_y_i and clears row/col; state_i selects which axis steps;
//        done_o = current axis finished, miss_o = offset beyond last column/row; in_sprite_o, row_o, col_o results.
module alien_hit_detector_grid_locator
    import alien_hit_detector_pkg::*;
(
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             start_i,
    input  state_t           state_i,
    input  logic [9:0]       rem_x_i,
    input  logic [9:0]       rem_y_i,
    output logic             done_o,
    output logic             miss_o,
    output logic             in_sprite_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o
);
    logic [9:0]       rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             x_ge, y_ge, x_last, y_last;

    assign x_ge   = rem_x_q >= 10'(PITCH_X);
    assign y_ge   = rem_y_q >= 10'(PITCH_Y);
    assign x_last = col_q == COL_W'(COLS - 1);
    assign y_last = row_q == ROW_W'(ROWS - 1);

    always_comb begin
        rem_x_d = rem_x_q;
        rem_y_d = rem_y_q;
        col_d   = col_q;
        row_d   = row_q;
        if (start_i) begin
            rem_x_d = rem_x_i;
            rem_y_d = rem_y_i;
            col_d   = '0;
            row_d   = '0;
        end else if (state_i == S_DIV_X && x_ge && !x_last) begin
            rem_x_d = rem_x_q - 10'(PITCH_X);
            col_d   = col_q + 1'b1;
        end else if (state_i == S_DIV_Y && y_ge && !y_last) begin
            rem_y_d = rem_y_q - 10'(PITCH_Y);
            row_d   = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            rem_x_q <= '0;
            rem_y_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // A remainder still >= pitch on the last column/row means the offset lies past the formation.
    assign done_o      = (state_i == S_DIV_X) ? !x_ge : !y_ge;
    assign miss_o      = (state_i == S_DIV_X) ? (x_ge && x_last) : (y_ge && y_last);
    assign in_sprite_o = (rem_x_q < 10'(ALIEN_W)) && (rem_y_q < 10'(ALIEN_H));
    assign row_o       = row_q;
    assign col_o       = col_q;
endmodule

// File: rtl/alien_hit_detector.sv
// alien_hit_detector: resolves the in-flight bullet against the alien grid, kills, scores and retires the shot.
// Ports: clk_25MHz, rst (async active-low); bus (slave side of the bullet link); grid_x/grid_y formation origin;
//        grid_reset new-wave request; alive bitmap, hit_row/hit_col of last kill, score, all_dead.
module alien_hit_detector
    import alien_hit_detector_pkg::*;
(
    input  logic                 clk_25MHz,
    input  logic                 rst,
    alien_hit_detector_if.slave  bus,
    input  logic [9:0]           grid_x,
    input  logic [9:0]           grid_y,
    input  logic                 grid_reset,
    output logic [N_CELLS-1:0]   alive,
    output logic [2:0]           hit_row,
    output logic [3:0]           hit_col,
    output logic [15:0]          score,
    output logic                 all_dead
);
    state_t             state_q;
    logic [N_CELLS-1:0] alive_q;
    logic [15:0]        score_q;
    logic [ROW_W-1:0]   hit_row_q;
    logic [COL_W-1:0]   hit_col_q;
    logic               hit_reset_q, all_dead_q;
    logic               start, done, miss, in_sprite;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [IDX_W-1:0]   idx;

    // Origin-relative offsets are only loaded when non-negative; a bullet above/left of the grid is a miss.
    assign start = state_q == S_IDLE && bus.bullet_active && bus.bullet_x >= grid_x && bus.bullet_y >= grid_y;
    assign idx   = cell_idx(row, col);

    alien_hit_detector_grid_locator u_loc (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .start_i     (start),
        .state_i     (state_q),
        .rem_x_i     (bus.bullet_x - grid_x),
        .rem_y_i     (bus.bullet_y - grid_y),
        .done_o      (done),
        .miss_o      (miss),
        .in_sprite_o (in_sprite),
        .row_o       (row),
        .col_o       (col)
    );

    // Kill side effects are registered on CHECK->HIT so they are visible exactly while in HIT.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            alive_q     <= '1;
            score_q     <= '0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
            hit_reset_q <= 1'b0;
            all_dead_q  <= 1'b0;
        end else begin
            hit_reset_q <= 1'b0;
            all_dead_q  <= alive_q == '0;
            if (grid_reset) begin
                alive_q <= '1;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:     state_q <= start ? S_DIV_X : S_IDLE;
                    S_DIV_X:    state_q <= miss ? S_IDLE : done ? S_DIV_Y : S_DIV_X;
                    S_DIV_Y:    state_q <= miss ? S_IDLE : done ? S_CHECK : S_DIV_Y;
                    S_CHECK: begin
                        if (in_sprite && alive_q[idx]) begin
                            state_q      <= S_HIT;
                            hit_reset_q  <= 1'b1;
                            alive_q[idx] <= 1'b0;
                            hit_row_q    <= row;
                            hit_col_q    <= col;
                            score_q      <= score_add(score_q);
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                    S_HIT:      state_q <= S_COOLDOWN;
                    S_COOLDOWN: state_q <= bus.bullet_active ? S_COOLDOWN : S_IDLE;
                    default:    state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.hit_reset = hit_reset_q;
    assign alive         = alive_q;
    assign hit_row       = hit_row_q;
    assign hit_col       = hit_col_q;
    assign score         = score_q;
    assign all_dead      = all_dead_q;
endmodule

// File: tb/tb_alien_hit_detector.sv
// tb_alien_hit_detector: directed self-checking bench for alien_hit_detector.
module tb_alien_hit_detector;
    import alien_hit_detector_pkg::*;

    logic               clk_25MHz = 1'b0;
    logic               rst = 1'b0;
    logic               grid_reset = 1'b0;
    logic [9:0]         grid_x = 10'd100;
    logic [9:0]         grid_y = 10'd50;
    logic [N_CELLS-1:0] alive;
    logic [2:0]         hit_row;
    logic [3:0]         hit_col;
    logic [15:0]        score;
    logic               all_dead;

    int                 total = 0;
    int                 bad = 0;
    logic [N_CELLS-1:0] exp_alive = 55'h7FFFFFFFFFFFFF;
    logic [15:0]        exp_score = 16'd0;

    alien_hit_detector_if bus();

    alien_hit_detector dut (
        .clk_25MHz  (clk_25MHz),
        .rst        (rst),
        .bus        (bus),
        .grid_x     (grid_x),
        .grid_y     (grid_y),
        .grid_reset (grid_reset),
        .alive      (alive),
        .hit_row    (hit_row),
        .hit_col    (hit_col),
        .score      (score),
        .all_dead   (all_dead)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    function automatic logic [15:0] sat(input logic [15:0] s);
        int t;
        t = int'(s) + 10;
        return (t > 65535) ? 16'hFFFF : 16'(t);
    endfunction

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic fire(input logic [9:0] x, input logic [9:0] y, input int ncyc, output int pulses, output int first);
        pulses = 0;
        first = 0;
        bus.bullet_x = x;
        bus.bullet_y = y;
        bus.bullet_active = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            if (bus.hit_reset) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        bus.bullet_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (alive !== 55'h7FFFFFFFFFFFFF) begin $display("FAIL reset_alive got=%h want=%h", alive, 55'h7FFFFFFFFFFFFF); bad++; end
        rst = 1'b1;
        tick();
        total++; if (alive !== 55'h7FFFFFFFFFFFFF) begin $display("FAIL post_reset_alive got=%h want=%h", alive, 55'h7FFFFFFFFFFFFF); bad++; end
        total++; if (score !== 16'd0) begin $display("FAIL reset_score got=%0d want=0", score); bad++; end
        total++; if (bus.hit_reset !== 1'b0) begin $display("FAIL reset_hit_reset got=%b want=0", bus.hit_reset); bad++; end
        total++; if (all_dead !== 1'b0) begin $display("FAIL reset_all_dead got=%b want=0", all_dead); bad++; end
        total++; if ({hit_row, hit_col} !== 7'd0) begin $display("FAIL reset_hit_pos got=%0d,%0d want=0,0", hit_row, hit_col); bad++; end
    endtask

    task automatic test_direct_hit();
        int p, f;
        fire(10'd105, 10'd55, 100, p, f);
        exp_alive[0] = 1'b0;
        exp_score = sat(exp_score);
        total++; if (p !== 1) begin $display("FAIL direct_pulses got=%0d want=1", p); bad++; end
        total++; if (f == 0 || f > 19) begin $display("FAIL direct_latency got=%0d want=1..19", f); bad++; end
        total++; if (f !== 4) begin $display("FAIL direct_latency_exact got=%0d want=4", f); bad++; end
        total++; if (alive !== exp_alive) begin $display("FAIL direct_alive got=%h want=%h", alive, exp_alive); bad++; end
        total++; if ({hit_row, hit_col} !== 7'd0) begin $display("FAIL direct_pos got=%0d,%0d want=0,0", hit_row, hit_col); bad++; end
        total++; if (score !== 16'd10) begin $display("FAIL direct_score got=%0d want=10", score); bad++; end
    endtask

    task automatic test_misses();
        logic [9:0] mx [5];
        logic [9:0] my [5];
        int p, f;
        mx = '{10'd116, 10'd99, 10'd364, 10'd105, 10'd105};
        my = '{10'd79,  10'd79, 10'd79,  10'd170, 10'd49};
        for (int k = 0; k < 5; k++) begin
            fire(mx[k], my[k], 30, p, f);
            total++; if (p !== 0) begin $display("FAIL miss%0d_pulses got=%0d want=0", k, p); bad++; end
            total++; if (alive !== exp_alive) begin $display("FAIL miss%0d_alive got=%h want=%h", k, alive, exp_alive); bad++; end
        end
        total++; if (score !== 16'd10) begin $display("FAIL miss_score got=%0d want=10", score); bad++; end
    endtask

    task automatic test_dead_alien();
        int p, f;
        fire(10'd105, 10'd55, 30, p, f);
        total++; if (p !== 0) begin $display("FAIL dead_pulses got=%0d want=0", p); bad++; end
        total++; if (score !== 16'd10) begin $display("FAIL dead_score got=%0d want=10", score); bad++; end
        fire(10'd343, 10'd149, 30, p, f);
        exp_alive[54] = 1'b0;
        exp_score = sat(exp_score);
        total++; if (p !== 1) begin $display("FAIL corner_pulses got=%0d want=1", p); bad++; end
        total++; if (hit_row !== 3'd4 || hit_col !== 4'd10) begin $display("FAIL corner_pos got=%0d,%0d want=4,10", hit_row, hit_col); bad++; end
        total++; if (alive !== exp_alive) begin $display("FAIL corner_alive got=%h want=%h", alive, exp_alive); bad++; end
        total++; if (score !== 16'd20) begin $display("FAIL corner_score got=%0d want=20", score); bad++; end
    endtask

    task automatic test_wave_clear();
        int p, f, n, idx;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 11; c++) begin
                idx = r * 11 + c;
                if (exp_alive[idx] && idx != 53) begin
                    fire(10'(100 + c * 24 + 3), 10'(50 + r * 24 + 3), 25, p, f);
                    exp_alive[idx] = 1'b0;
                    exp_score = sat(exp_score);
                    total++; if (p !== 1) begin $display("FAIL wave_kill r%0d c%0d pulses got=%0d want=1", r, c, p); bad++; end
                end
            end
        end
        total++; if (alive !== exp_alive) begin $display("FAIL wave_alive got=%h want=%h", alive, exp_alive); bad++; end
        bus.bullet_x = 10'd319;
        bus.bullet_y = 10'd149;
        bus.bullet_active = 1'b1;
        n = 0;
        while (!bus.hit_reset && n < 30) begin
            tick();
            n++;
        end
        exp_alive[53] = 1'b0;
        exp_score = sat(exp_score);
        total++; if (bus.hit_reset !== 1'b1) begin $display("FAIL last_kill_timeout got=%b want=1", bus.hit_reset); bad++; end
        total++; if (alive !== 55'd0) begin $display("FAIL last_alive got=%h want=0", alive); bad++; end
        total++; if (all_dead !== 1'b0) begin $display("FAIL all_dead_early got=%b want=0", all_dead); bad++; end
        total++; if (hit_row !== 3'd4 || hit_col !== 4'd9) begin $display("FAIL last_pos got=%0d,%0d want=4,9", hit_row, hit_col); bad++; end
        tick();
        total++; if (all_dead !== 1'b1) begin $display("FAIL all_dead got=%b want=1", all_dead); bad++; end
        total++; if (score !== 16'd550 || exp_score !== 16'd550) begin $display("FAIL wave_score got=%0d want=550", score); bad++; end
        bus.bullet_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_grid_reset();
        grid_reset = 1'b1;
        tick();
        grid_reset = 1'b0;
        exp_alive = 55'h7FFFFFFFFFFFFF;
        total++; if (alive !== 55'h7FFFFFFFFFFFFF) begin $display("FAIL grst_alive got=%h want=%h", alive, 55'h7FFFFFFFFFFFFF); bad++; end
        total++; if (score !== 16'd550) begin $display("FAIL grst_score got=%0d want=550", score); bad++; end
        total++; if (bus.hit_reset !== 1'b0) begin $display("FAIL grst_hit_reset got=%b want=0", bus.hit_reset); bad++; end
        tick();
        total++; if (all_dead !== 1'b0) begin $display("FAIL grst_all_dead got=%b want=0", all_dead); bad++; end
    endtask

    task automatic test_grid_reset_mid();
        int p;
        p = 0;
        bus.bullet_x = 10'd343;
        bus.bullet_y = 10'd53;
        bus.bullet_active = 1'b1;
        tick();
        bus.bullet_active = 1'b0;
        grid_reset = 1'b1;
        tick();
        grid_reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.hit_reset) p++;
        end
        total++; if (p !== 0) begin $display("FAIL mid_grst_pulses got=%0d want=0", p); bad++; end
        total++; if (alive !== exp_alive) begin $display("FAIL mid_grst_alive got=%h want=%h", alive, exp_alive); bad++; end
        total++; if (score !== 16'd550) begin $display("FAIL mid_grst_score got=%0d want=550", score); bad++; end
    endtask

    task automatic test_saturation();
        int kills;
        kills = 0;
        bus.bullet_x = 10'd105;
        bus.bullet_y = 10'd55;
        bus.bullet_active = 1'b1;
        for (int i = 0; i < 40000 && kills < 6500; i++) begin
            tick();
            if (bus.hit_reset) begin
                kills++;
                exp_score = sat(exp_score);
                total++;
                if (score !== exp_score) begin
                    if (bad < 20) $display("FAIL sat_kill%0d_score got=%0d want=%0d", kills, score, exp_score);
                    bad++;
                end
                grid_reset = 1'b1;
                tick();
                grid_reset = 1'b0;
            end
        end
        bus.bullet_active = 1'b0;
        tick();
        tick();
        total++; if (kills !== 6500) begin $display("FAIL sat_kills got=%0d want=6500", kills); bad++; end
        total++; if (score !== 16'hFFFF) begin $display("FAIL sat_final got=%h want=ffff", score); bad++; end
    endtask

    initial begin
        bus.bullet_x = 10'd0;
        bus.bullet_y = 10'd0;
        bus.bullet_active = 1'b0;
        test_reset();
        test_direct_hit();
        test_misses();
        test_dead_alien();
        test_wave_clear();
        test_grid_reset();
        test_grid_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
